// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes, default latencies, state encodings.
// The divider is present only when MDU_DIV_EN is defined; otherwise div/divu decode as no-ops.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return ((op == MD_DIV) || (op == MD_DIVU)) && DIV_EN;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product plus quotient/remainder and divide-by-zero flag from latched operands.
// Divider logic exists only under MDU_DIV_EN; otherwise quotient/remainder are tied off.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  always_comb begin
    if (op == MD_MULT) begin
      prod = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    end else begin
      prod = {32'd0, a} * {32'd0, b};
    end
  end

`ifdef MDU_DIV_EN
  always_comb begin
    quot     = '0;
    rem      = '0;
    div_zero = 1'b0;
    if (b == 32'd0) begin
      div_zero = is_div_op(op);
    end else if (op == MD_DIV) begin
      // The one signed quotient that does not fit; defined result rather than relying on tool behaviour.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        quot = 32'h8000_0000;
      end else begin
        quot = 32'($signed(a) / $signed(b));
        rem  = 32'($signed(a) % $signed(b));
      end
    end else begin
      quot = a / b;
      rem  = a % b;
    end
  end
`else
  assign quot     = '0;
  assign rem      = '0;
  assign div_zero = 1'b0;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller: issues one op from EX, runs a busy down-counter, commits HI/LO on terminal count.
// div/divu are honoured only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = 16;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div_zero;

  mdu_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mult_op(MDop) || is_div_op(MDop)) begin
            op_d    = MDop;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_div_op(MDop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = ST_RUN;
          end else if (MDop == MD_MTHI) begin
            hi_d = A;
          end else if (MDop == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (is_mult_op(op_q)) begin
            {hi_d, lo_d} = prod;
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign stall_req = busy | (start & (is_mult_op(MDop) | is_div_op(MDop)));
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {HI,LO} queued at issue, compared when the op retires.
// Div checks follow MDU_DIV_EN the same way the design does.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a_in, b_in;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] exp_q[$];

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDop      (md_op),
    .A         (a_in),
    .B         (b_in),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (hi),
    .LO        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULT) return 64'(sa * sb);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Caller is positioned at a negedge; leaves start low just after the issue edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic exp_stall);
    start = 1'b1;
    md_op = op;
    a_in  = a;
    b_in  = b;
    #1;
    check("stall_issue", stall_req, exp_stall);
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
    end
  endtask

  // Counts busy cycles (bounded), scrambling A/B to prove operands were captured at issue.
  task automatic wait_done(input int exp_cyc, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      a_in = $urandom;
      b_in = $urandom;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, exp_cyc);
    pop_check(tag);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_stall", stall_req, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_done(5, "mult");

    // Issued in the first cycle busy is low again.
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(5, "multu");

    exp_q.push_back({32'h1234_5678, m_lo});
    issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_busy_edge", busy, 0);
    @(negedge clk);
    check("mthi_busy", busy, 0);
    pop_check("mthi");

    exp_q.push_back({m_hi, 32'hCAFE_F00D});
    issue(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    @(negedge clk);
    pop_check("mtlo");

    issue(4'd7, 32'h1111_1111, 32'h2222_2222, 1'b0);
    @(negedge clk);
    check("none_busy", busy, 0);
    check("none_hi", hi, m_hi);
    check("none_lo", lo, m_lo);

    // New mult and mthi during busy must both be ignored.
    exp_q.push_back({32'd0, 32'd12});
    issue(MD_MULT, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    issue(MD_MULT, 32'd100, 32'd100, 1'b1);
    @(negedge clk);
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    @(negedge clk);
    check("ign_mthi_hi", hi, m_hi);
    wait_done(2, "ignore");

`ifdef MDU_DIV_EN
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(10, "div");
    exp_q.push_back({m_hi, m_lo});
    issue(MD_DIVU, 32'd7, 32'd0, 1'b1);
    wait_done(10, "div0");
    exp_q.push_back({32'd0, 32'h8000_0000});
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(10, "div_ovf");
    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(10, "div_negb");
    exp_q.push_back({32'd1, 32'd33});
    issue(MD_DIVU, 32'd100, 32'd3, 1'b1);
    wait_done(10, "divu");
`else
    issue(MD_DIV, 32'd8, 32'd2, 1'b0);
    check("nodiv_busy_edge", busy, 0);
    @(negedge clk);
    check("nodiv_busy", busy, 0);
    check("nodiv_hi", hi, m_hi);
    check("nodiv_lo", lo, m_lo);
    issue(MD_DIVU, 32'd9, 32'd3, 1'b0);
    @(negedge clk);
    check("nodivu_busy", busy, 0);
    check("nodivu_lo", lo, m_lo);
`endif

    for (int i = 0; i < 6; i++) begin
      logic [3:0]  op;
      logic [31:0] ra, rb;
      op = ($urandom_range(0, 1) == 0) ? MD_MULT : MD_MULTU;
      ra = $urandom;
      rb = $urandom;
      exp_q.push_back(model(op, ra, rb));
      issue(op, ra, rb, 1'b1);
      wait_done(5, "rnd_mult");
    end

    // Reset in the third busy cycle: abort, clear, never commit.
    issue(MD_MULT, 32'd5, 32'd7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstrun_busy", busy, 0);
    check("rstrun_hi", hi, 0);
    check("rstrun_lo", lo, 0);
    repeat (8) @(negedge clk);
    check("rstrun_late_busy", busy, 0);
    check("rstrun_late_lo", lo, 0);
    check("sb_final_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
